mux2_rr_arbiter: RTL
====================

Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 mux datapath between two requesters.
- Each requester presents a WIDTH-bit word plus a request line.
- The block grants one requester at a time, drives the mux select, and forwards the granted word to a single output channel.
- Sits directly in front of the gate-level 2:1 mux stage and owns its select line.

Parameters:
- WIDTH, 1: data width of each requester word and of out_data.
- MAX_HOLD, 8: cycles a grant may be held while the other side waits; used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 wants the channel.
- req1  input  1  requester 1 wants the channel.
- in0_data  input  WIDTH  requester 0 word.
- in1_data  input  WIDTH  requester 1 word.
- gnt0  output  1  requester 0 owns the channel (registered).
- gnt1  output  1  requester 1 owns the channel (registered).
- sel  output  1  mux select: 0 = in0_data, 1 = in1_data (registered).
- out_valid  output  1  out_data carries a granted word.
- out_data  output  WIDTH  sel ? in1_data : in0_data, combinational from registered sel.

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately on rst_n low.
  - State = IDLE; gnt0 = 0, gnt1 = 0, sel = 0, last = 1 (so port 0 wins the first tie).
  - Hold counter = 0; out_valid = 0.
- FSM states: IDLE, G0, G1. gnt0 = (state == G0); gnt1 = (state == G1); never both high.
- IDLE:
  - req0 & req1 -> grant the port opposite to last.
  - req0 only -> G0.
  - req1 only -> G1.
  - Neither -> stay in IDLE.
  - Grant appears on the clock edge after the request is sampled (1-cycle latency).
- G0:
  - Stay while req0 = 1 (locked grant).
  - On req0 = 0: go to G1 if req1 = 1, with no idle bubble; otherwise go to IDLE.
- G1: symmetric to G0.
- Every transition into Gx sets sel = x and last = x.
- In IDLE, sel holds its previous value, so out_data keeps tracking that input with out_valid = 0.
- out_valid = (gnt0 & req0) | (gnt1 & req1), combinational. It drops in the same cycle the owner releases req, before the grant falls.
- Simultaneous release of the owner and a new request from the other side: the handover completes on the next edge.
- Request held through reset: after rst_n rises, the grant follows on the first sampling edge per the IDLE rules.
- A requester must not change in_x_data expecting it to be ignored while it is granted; the word passes straight through.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to any Gx and increments each cycle in Gx.
  - When counter == MAX_HOLD-1 and the other req = 1, the FSM moves to the other Gx on the next edge even if the owner's req is still high.
  - If the other req = 0, the counter saturates and the grant is kept.
- Not defined:
  - No counter is built.
  - A grant lasts until the owner drops req, so a requester can starve the other indefinitely.

Test Plan:
- Reset: rst_n = 0 with req0 = req1 = 1 -> gnt0 = gnt1 = 0, sel = 0, out_valid = 0; release reset -> gnt0 = 1 at the first edge (last = 1 tiebreak).
- Single requester: req1 = 1 for 4 cycles, in1_data = 1, in0_data = 0 -> gnt1 = 1 one edge later for 4 cycles, sel = 1, out_data = 1, out_valid = 1; then IDLE with sel staying 1.
- Tie alternation: req0 and req1 pulsed high together for 1 grant cycle each, three times -> grant order 0, 1, 0.
- Handover without bubble: G0 held, req1 = 1, drop req0 -> gnt1 = 1 on the very next edge, no IDLE cycle, sel 0->1.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD = 4): req0 constantly high from cycle 0, req1 raised at cycle 1 -> gnt0 for exactly 4 cycles, then gnt1. Without the macro -> gnt0 stays high until req0 drops.
- Async reset mid-grant: assert rst_n low between edges during G1 -> gnt1 and sel go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Two-port round-robin arbiter that owns the select of a 2:1 word mux.
// Define ARB_TIMEOUT_EN to force a handover after MAX_HOLD cycles when the other side is waiting.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in0_data,
  input  logic [WIDTH-1:0] in1_data,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux2_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last;
  logic       entering;
  logic       expired;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  assign expired = (hold_cnt == HOLD_LAST);

  // Counter sticks at HOLD_LAST so a late request from the other side still wins at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if (entering) begin
      hold_cnt <= 8'd0;
    end else if (state != IDLE && !expired) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? G0 : G1;
        else if (req0)     state_nxt = G0;
        else if (req1)     state_nxt = G1;
      end
      G0: begin
        if (req1 && (expired || !req0)) state_nxt = G1;
        else if (!req0)                 state_nxt = IDLE;
      end
      G1: begin
        if (req0 && (expired || !req1)) state_nxt = G0;
        else if (!req1)                 state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign entering = (state_nxt != state) && (state_nxt != IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (entering) begin
        sel  <= (state_nxt == G1);
        last <= (state_nxt == G1);
      end
    end
  end

  assign gnt0      = (state == G0);
  assign gnt1      = (state == G1);
  assign out_valid = (gnt0 & req0) | (gnt1 & req1);
  assign out_data  = sel ? in1_data : in0_data;

endmodule
